// File: rtl/ipif_cmd_master_if.sv
// Command/response channel plus IPIF bus bundle for ipif_cmd_master.
// master = initiator side (the design); slave = controller + register responders.
interface ipif_cmd_master_if #(
  parameter int C_S_AXI_ADDR_WIDTH = 32,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int NCS                = 1,
  parameter int N_REG              = 2
);
  logic                              cmd_valid;
  logic                              cmd_ready;
  logic                              cmd_rnw;
  logic [C_S_AXI_ADDR_WIDTH-1:0]     cmd_addr;
  logic [C_S_AXI_DATA_WIDTH-1:0]     cmd_wdata;
  logic [C_S_AXI_DATA_WIDTH/8-1:0]   cmd_be;
  logic                              rsp_valid;
  logic                              rsp_ready;
  logic [C_S_AXI_DATA_WIDTH-1:0]     rsp_rdata;
  logic [1:0]                        rsp_status;
  logic                              IPIF_Bus2IP_resetn;
  logic [C_S_AXI_ADDR_WIDTH-1:0]     IPIF_Bus2IP_Addr;
  logic                              IPIF_Bus2IP_RNW;
  logic [C_S_AXI_DATA_WIDTH/8-1:0]   IPIF_Bus2IP_BE;
  logic [NCS-1:0]                    IPIF_Bus2IP_CS;
  logic [NCS*N_REG-1:0]              IPIF_Bus2IP_RdCE;
  logic [NCS*N_REG-1:0]              IPIF_Bus2IP_WrCE;
  logic [C_S_AXI_DATA_WIDTH-1:0]     IPIF_Bus2IP_Data;
  logic [C_S_AXI_DATA_WIDTH-1:0]     IPIF_IP2Bus_Data;
  logic                              IPIF_IP2Bus_WrAck;
  logic                              IPIF_IP2Bus_RdAck;
  logic                              IPIF_IP2Bus_Error;

  modport master (
    input  cmd_valid, cmd_rnw, cmd_addr, cmd_wdata, cmd_be, rsp_ready,
           IPIF_IP2Bus_Data, IPIF_IP2Bus_WrAck, IPIF_IP2Bus_RdAck, IPIF_IP2Bus_Error,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_status,
           IPIF_Bus2IP_resetn, IPIF_Bus2IP_Addr, IPIF_Bus2IP_RNW, IPIF_Bus2IP_BE,
           IPIF_Bus2IP_CS, IPIF_Bus2IP_RdCE, IPIF_Bus2IP_WrCE, IPIF_Bus2IP_Data
  );

  modport slave (
    output cmd_valid, cmd_rnw, cmd_addr, cmd_wdata, cmd_be, rsp_ready,
           IPIF_IP2Bus_Data, IPIF_IP2Bus_WrAck, IPIF_IP2Bus_RdAck, IPIF_IP2Bus_Error,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_status,
           IPIF_Bus2IP_resetn, IPIF_Bus2IP_Addr, IPIF_Bus2IP_RNW, IPIF_Bus2IP_BE,
           IPIF_Bus2IP_CS, IPIF_Bus2IP_RdCE, IPIF_Bus2IP_WrCE, IPIF_Bus2IP_Data
  );
endinterface

// File: rtl/ipif_cmd_master.sv
// IPIF initiator: one valid/ready register command -> one CS/CE bus cycle -> one response.
// Strobes appear the cycle after accept; response the cycle after ack/timeout; one command in flight.
module ipif_cmd_master #(
  parameter int C_S_AXI_ADDR_WIDTH = 32,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int NCS                = 1,
  parameter int N_REG              = 2,
  parameter int TIMEOUT            = 255
) (
  input logic               clk,
  input logic               reset,
  ipif_cmd_master_if.master bus
);
  localparam int AW = C_S_AXI_ADDR_WIDTH;
  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int NR = NCS * N_REG;
  localparam int CW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t            state_q, state_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]     rsp_rdata_q, rsp_rdata_d;
  logic [1:0]        rsp_status_q, rsp_status_d;
  logic              resetn_q, resetn_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic              rnw_q, rnw_d;
  logic [DW/8-1:0]   be_q, be_d;
  logic [DW-1:0]     data_q, data_d;
  logic [NCS-1:0]    cs_q, cs_d;
  logic [NR-1:0]     rdce_q, rdce_d;
  logic [NR-1:0]     wrce_q, wrce_d;
  logic [CW-1:0]     tmo_q, tmo_d;

  logic [AW-1:0]     reg_idx;
  logic [NCS-1:0]    cs_hot;
  logic [NR-1:0]     ce_hot;
  logic              ack;

  always_comb begin
    reg_idx = bus.cmd_addr >> 2;
    for (int j = 0; j < NCS; j++)
      cs_hot[j] = (reg_idx >= AW'(j * N_REG)) && (reg_idx < AW'((j + 1) * N_REG));
    for (int i = 0; i < NR; i++)
      ce_hot[i] = (reg_idx == AW'(i));
  end

  // Only the ack matching the latched direction terminates the access.
  assign ack = rnw_q ? bus.IPIF_IP2Bus_RdAck : bus.IPIF_IP2Bus_WrAck;

  always_comb begin
    state_d      = state_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_rdata_d  = rsp_rdata_q;
    rsp_status_d = rsp_status_q;
    resetn_d     = 1'b1;
    addr_d       = addr_q;
    rnw_d        = rnw_q;
    be_d         = be_q;
    data_d       = data_q;
    cs_d         = cs_q;
    rdce_d       = rdce_q;
    wrce_d       = wrce_q;
    tmo_d        = tmo_q;

    case (state_q)
      IDLE: begin
        if (bus.cmd_valid && cmd_ready_q) begin
          addr_d = bus.cmd_addr;
          rnw_d  = bus.cmd_rnw;
          be_d   = bus.cmd_be;
          data_d = bus.cmd_wdata;
          tmo_d  = '0;
          if (reg_idx >= AW'(NR)) begin
            state_d      = RESP;
            rsp_valid_d  = 1'b1;
            rsp_rdata_d  = '0;
            rsp_status_d = 2'b11;
          end else begin
            state_d = ACCESS;
            cs_d    = cs_hot;
            rdce_d  = bus.cmd_rnw ? ce_hot : '0;
            wrce_d  = bus.cmd_rnw ? '0 : ce_hot;
          end
        end
      end
      ACCESS: begin
        if (ack) begin
          state_d      = RESP;
          cs_d         = '0;
          rdce_d       = '0;
          wrce_d       = '0;
          rsp_valid_d  = 1'b1;
          rsp_rdata_d  = rnw_q ? bus.IPIF_IP2Bus_Data : '0;
          rsp_status_d = bus.IPIF_IP2Bus_Error ? 2'b01 : 2'b00;
        end else if (tmo_q == CW'(TIMEOUT - 1)) begin
          state_d      = RESP;
          cs_d         = '0;
          rdce_d       = '0;
          wrce_d       = '0;
          rsp_valid_d  = 1'b1;
          rsp_rdata_d  = '0;
          rsp_status_d = 2'b10;
        end else begin
          tmo_d = tmo_q + CW'(1);
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    cmd_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cmd_ready_q  <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= '0;
      rsp_status_q <= '0;
      resetn_q     <= 1'b0;
      addr_q       <= '0;
      rnw_q        <= 1'b0;
      be_q         <= '0;
      data_q       <= '0;
      cs_q         <= '0;
      rdce_q       <= '0;
      wrce_q       <= '0;
      tmo_q        <= '0;
    end else begin
      state_q      <= state_d;
      cmd_ready_q  <= cmd_ready_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_status_q <= rsp_status_d;
      resetn_q     <= resetn_d;
      addr_q       <= addr_d;
      rnw_q        <= rnw_d;
      be_q         <= be_d;
      data_q       <= data_d;
      cs_q         <= cs_d;
      rdce_q       <= rdce_d;
      wrce_q       <= wrce_d;
      tmo_q        <= tmo_d;
    end
  end

  assign bus.cmd_ready          = cmd_ready_q;
  assign bus.rsp_valid          = rsp_valid_q;
  assign bus.rsp_rdata          = rsp_rdata_q;
  assign bus.rsp_status         = rsp_status_q;
  assign bus.IPIF_Bus2IP_resetn = resetn_q;
  assign bus.IPIF_Bus2IP_Addr   = addr_q;
  assign bus.IPIF_Bus2IP_RNW    = rnw_q;
  assign bus.IPIF_Bus2IP_BE     = be_q;
  assign bus.IPIF_Bus2IP_Data   = data_q;
  assign bus.IPIF_Bus2IP_CS     = cs_q;
  assign bus.IPIF_Bus2IP_RdCE   = rdce_q;
  assign bus.IPIF_Bus2IP_WrCE   = wrce_q;
endmodule
